// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single UART transmitter (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined); one frame at a time, all outputs registered.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 650
) (
  input  logic                       Clock_In,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [8*NUM_REQ-1:0]       Data_In,
  output logic [NUM_REQ-1:0]         Ack,
  output logic [$clog2(NUM_REQ)-1:0] Grant_Id,
  output logic                       Busy,
  output logic                       Tx_Out
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_reg, state_next;
  logic [15:0]        cnt_reg, cnt_next;
  logic [2:0]         bit_reg, bit_next;
  logic [7:0]         shift_reg, shift_next;
  logic               tx_reg, tx_next;
  logic               busy_reg, busy_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [IDW-1:0]     grant_reg, grant_next;
  logic [IDW-1:0]     last_reg, last_next;
`ifdef UART_TX_PARITY_EN
  logic               par_reg, par_next;
`endif

  logic               found;
  logic [IDW-1:0]     winner;
  logic [IDW:0]       sum;
  logic [NUM_REQ-1:0] win_onehot;
  logic               bit_done;

  // Search upward from the slot after the last winner, wrapping once.
  always_comb begin
    found  = 1'b0;
    winner = last_reg;
    sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_reg} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (!found && Req[sum[IDW-1:0]]) begin
        found  = 1'b1;
        winner = sum[IDW-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (winner == IDW'(gi));
    end
  endgenerate

  assign bit_done = (cnt_reg == BIT_END);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 16'd1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    ack_next   = '0;
    grant_next = grant_reg;
    last_next  = last_reg;
`ifdef UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (found) begin
          state_next = START;
          shift_next = Data_In[{winner, 3'b000} +: 8];
`ifdef UART_TX_PARITY_EN
          par_next   = ^Data_In[{winner, 3'b000} +: 8];
`endif
          grant_next = winner;
          last_next  = winner;
          ack_next   = win_onehot;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          cnt_next   = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next = '0;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = par_reg;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            // Next bit comes from the shifted copy, so tx tracks shift_next[0].
            bit_next   = bit_reg + 3'd1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          cnt_next   = '0;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
          cnt_next   = '0;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock_In or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      ack_reg   <= '0;
      grant_reg <= '0;
      last_reg  <= IDW'(NUM_REQ - 1);
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      ack_reg   <= ack_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
`ifdef UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  assign Tx_Out   = tx_reg;
  assign Busy     = busy_reg;
  assign Ack      = ack_reg;
  assign Grant_Id = grant_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with CLKS_PER_BIT=4, NUM_REQ=4;
// builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_scheduler;
  localparam int CPB = 4;
  localparam int NR  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [8*NR-1:0] data_in;
  logic [NR-1:0] ack;
  logic [1:0]    grant;
  logic          busy;
  logic          tx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
    .Clock_In(clk),
    .Reset(rst),
    .Req(req),
    .Data_In(data_in),
    .Ack(ack),
    .Grant_Id(grant),
    .Busy(busy),
    .Tx_Out(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       par;   // hand-computed even parity of data
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit k of the result is the k-th bit on the line.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {1'b1, 1'b1, d, 1'b0};
`endif
  endfunction

  // Returns at the first negedge where Ack is seen (cycle 0 of the frame).
  task automatic wait_ack(input int exp_idx, input string tag);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ack == '0 && waited < 50);
    $display("ack %s: ack=%b grant=%0d cycle=%0d", tag, ack, grant, cyc);
    check({tag, "_ack"}, 32'(ack), 32'(1) << exp_idx);
    check({tag, "_grant"}, 32'(grant), 32'(exp_idx));
    check({tag, "_start"}, {30'd0, busy, tx}, 32'b10);
  endtask

  task automatic capture_frame(input logic [10:0] exp_bits, input string tag,
                               input int drop_idx, input int drop_at);
    logic [10:0] obs;
    int busy_cnt, ack_cnt, unstable;
    obs = '1; busy_cnt = 0; ack_cnt = 0; unstable = 0;
    for (int c = 0; c < FRAME * CPB; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) begin
        req[drop_idx] = 1'b0;
        data_in[drop_idx*8 +: 8] = 8'hFF;
      end
      if (busy) busy_cnt++;
      if (c > 0 && ack != '0) ack_cnt++;
      if (c % CPB == 0) obs[c / CPB] = tx;
      else if (tx !== obs[c / CPB]) unstable++;
    end
    @(negedge clk);
    $display("frame %s: bits=%b busy_cycles=%0d", tag, obs, busy_cnt);
    check({tag, "_bits"}, 32'(obs), 32'(exp_bits));
    check({tag, "_busy_len"}, 32'(busy_cnt), 32'(FRAME * CPB));
    check({tag, "_stable"}, 32'(unstable), 32'd0);
    check({tag, "_single_ack"}, 32'(ack_cnt), 32'd0);
    check({tag, "_end_idle"}, {30'd0, busy, tx}, 32'b01);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [7:0] rr_par;
    int bad, prev_start, cnt;

    vecs[0] = '{idx: 2, data: 8'hA5, par: 1'b0};
    vecs[1] = '{idx: 0, data: 8'h07, par: 1'b1};
    vecs[2] = '{idx: 3, data: 8'h03, par: 1'b0};
    vecs[3] = '{idx: 1, data: 8'hFF, par: 1'b0};
    vecs[4] = '{idx: 0, data: 8'h00, par: 1'b0};
    vecs[5] = '{idx: 1, data: 8'h80, par: 1'b1};
    rr_par  = 8'b1001;   // parity of 0x10,0x11,0x12,0x13 at bits 0..3

    rst = 1'b1; req = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_values", {27'd0, grant, ack != '0, busy, tx}, 32'b00_0_0_1);
    rst = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || ack !== '0) bad++;
    end
    check("idle_hold_100", 32'(bad), 32'd0);

    foreach (vecs[v]) begin
      req[vecs[v].idx] = 1'b1;
      data_in[vecs[v].idx*8 +: 8] = vecs[v].data;
      wait_ack(vecs[v].idx, $sformatf("vec%0d", v));
      req[vecs[v].idx] = 1'b0;
      capture_frame(frame_bits(vecs[v].data, vecs[v].par), $sformatf("vec%0d", v), -1, -1);
    end

    // Round-robin: all requests held high.
    do_reset();
    data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    prev_start = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack(i % NR, $sformatf("rr%0d", i));
      if (i > 0) check($sformatf("rr%0d_spacing", i), 32'(cyc - prev_start), 32'(FRAME * CPB + 1));
      prev_start = cyc;
      if (i == 4) req = '0;
      capture_frame(frame_bits(8'h10 + 8'(i % NR), rr_par[i % NR]), $sformatf("rr%0d", i), -1, -1);
    end

    // Reset during data bit 3 (cycles 16..19 of the frame).
    do_reset();
    req[2] = 1'b1;
    data_in[2*8 +: 8] = 8'hA5;
    wait_ack(2, "mid");
    req[2] = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_pre_reset", {30'd0, busy, tx}, 32'b10);
    rst = 1'b1;
    #1;
    check("mid_async_reset", {27'd0, grant, ack != '0, busy, tx}, 32'b00_0_0_1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req[1] = 1'b1;
    data_in[1*8 +: 8] = 8'h3C;
    wait_ack(1, "post_reset");
    req[1] = 1'b0;
    capture_frame(frame_bits(8'h3C, 1'b0), "post_reset", -1, -1);

    // Drop Req[0] mid-frame: frame unchanged, no further Ack[0].
    do_reset();
    req[0] = 1'b1;
    data_in[0 +: 8] = 8'h96;
    wait_ack(0, "drop");
    capture_frame(frame_bits(8'h96, 1'b0), "drop", 0, 10);
    cnt = 0;
    bad = 0;
    repeat (3 * (FRAME * CPB + 1)) begin
      @(negedge clk);
      if (ack != '0) cnt++;
      if (busy) bad++;
    end
    check("drop_no_reack", 32'(cnt), 32'd0);
    check("drop_stays_idle", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
